// File: rtl/trees_dma_loader_if.sv
// ESP-style DMA read interface: a request channel (ctrl) and a 64-bit beat channel (chnl).
// The loader is the master; the DMA engine (or a bench model of it) is the slave.
interface trees_dma_loader_if;
  logic        dma_read_ctrl_valid;
  logic        dma_read_ctrl_ready;
  logic [31:0] dma_read_ctrl_data_index;
  logic [31:0] dma_read_ctrl_data_length;
  logic [2:0]  dma_read_ctrl_data_size;
  logic        dma_read_chnl_valid;
  logic        dma_read_chnl_ready;
  logic [63:0] dma_read_chnl_data;

  modport master (
    output dma_read_ctrl_valid,
    input  dma_read_ctrl_ready,
    output dma_read_ctrl_data_index,
    output dma_read_ctrl_data_length,
    output dma_read_ctrl_data_size,
    input  dma_read_chnl_valid,
    output dma_read_chnl_ready,
    input  dma_read_chnl_data
  );

  modport slave (
    input  dma_read_ctrl_valid,
    output dma_read_ctrl_ready,
    input  dma_read_ctrl_data_index,
    input  dma_read_ctrl_data_length,
    input  dma_read_ctrl_data_size,
    output dma_read_chnl_valid,
    input  dma_read_chnl_ready,
    output dma_read_chnl_data
  );
endinterface

// File: rtl/trees_dma_loader.sv
// DMA input stage for the tree-inference core: bursts tree nodes into tree memory, then
// streams one sample at a time into the feature buffer with a valid/ready hand-off.
module trees_dma_loader #(
  parameter int unsigned N_TREES    = 128,
  parameter int unsigned N_NODES    = 256,
  parameter int unsigned N_FEATURES = 32,
  parameter int unsigned MAX_BURST  = 256
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  load_trees,
  input  logic [15:0]                           n_samples,
  input  logic [31:0]                           base_index,
  trees_dma_loader_if.master                    dma,
  output logic                                  tree_we,
  output logic [$clog2(N_TREES*N_NODES)-1:0]    tree_addr,
  output logic [63:0]                           tree_wdata,
  output logic                                  feat_we,
  output logic [$clog2(N_FEATURES/2)-1:0]       feat_addr,
  output logic [63:0]                           feat_wdata,
  output logic                                  sample_valid,
  input  logic                                  sample_ready,
  output logic                                  busy,
  output logic                                  done
);

  localparam int unsigned TotalBeats = N_TREES * N_NODES;
  localparam int unsigned FeatBeats  = N_FEATURES / 2;
  localparam int unsigned TreeAw     = $clog2(TotalBeats);
  localparam int unsigned BurstAw    = $clog2(MAX_BURST);
  localparam int unsigned FeatAw     = $clog2(FeatBeats);

  typedef enum logic [2:0] {
    StIdle, StTreeReq, StTreeData, StFeatReq, StFeatData, StSampleHs, StDone
  } state_e;

  state_e              state_q, state_d;
  logic                load_trees_q;
  logic [15:0]         n_samples_q;
  logic [31:0]         base_index_q;
  logic [15:0]         sample_q;
  logic [TreeAw:0]     tree_cnt_q;
  logic [FeatAw-1:0]   feat_cnt_q;
  logic                sample_valid_q;

  logic                beat;
  logic                tree_burst_end;
  logic                tree_last;
  logic                feat_last;
  logic [16:0]         sample_next;
  logic                more_samples;
  logic [31:0]         tree_index;
  logic [31:0]         feat_index;

  assign beat           = dma.dma_read_chnl_valid & dma.dma_read_chnl_ready;
  // MAX_BURST divides the tree image, so burst boundaries are the low count bits all set.
  assign tree_burst_end = &tree_cnt_q[BurstAw-1:0];
  assign tree_last      = &tree_cnt_q[TreeAw-1:0];
  assign feat_last      = &feat_cnt_q;
  assign sample_next    = {1'b0, sample_q} + 17'd1;
  assign more_samples   = sample_next < {1'b0, n_samples_q};
  assign tree_index     = base_index_q + 32'(tree_cnt_q);
  assign feat_index     = base_index_q + (load_trees_q ? 32'(TotalBeats) : 32'd0)
                        + 32'(sample_q) * 32'(FeatBeats);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (load_trees)            state_d = StTreeReq;
          else if (n_samples != '0)  state_d = StFeatReq;
          else                       state_d = StDone;
        end
      end
      StTreeReq:  if (dma.dma_read_ctrl_ready) state_d = StTreeData;
      StTreeData: begin
        if (beat && tree_burst_end) begin
          if (!tree_last)                state_d = StTreeReq;
          else if (n_samples_q != '0)    state_d = StFeatReq;
          else                           state_d = StDone;
        end
      end
      StFeatReq:  if (dma.dma_read_ctrl_ready) state_d = StFeatData;
      StFeatData: if (beat && feat_last) state_d = StSampleHs;
      StSampleHs: if (sample_ready) state_d = more_samples ? StFeatReq : StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_trees_q   <= 1'b0;
      n_samples_q    <= '0;
      base_index_q   <= '0;
      sample_q       <= '0;
      tree_cnt_q     <= '0;
      feat_cnt_q     <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= (state_d == StSampleHs);
      if (state_q == StIdle && start) begin
        load_trees_q <= load_trees;
        n_samples_q  <= n_samples;
        base_index_q <= base_index;
        sample_q     <= '0;
        tree_cnt_q   <= '0;
        feat_cnt_q   <= '0;
      end
      if (state_q == StTreeData && beat) tree_cnt_q <= tree_cnt_q + 1'b1;
      // Wraps back to 0 after the last beat, ready for the next sample.
      if (state_q == StFeatData && beat) feat_cnt_q <= feat_cnt_q + 1'b1;
      if (state_q == StSampleHs && sample_ready) sample_q <= sample_q + 16'd1;
    end
  end

  always_comb begin
    dma.dma_read_ctrl_valid       = 1'b0;
    dma.dma_read_ctrl_data_index  = '0;
    dma.dma_read_ctrl_data_length = '0;
    dma.dma_read_chnl_ready       = 1'b0;
    tree_we                       = 1'b0;
    tree_wdata                    = '0;
    feat_we                       = 1'b0;
    feat_wdata                    = '0;
    unique case (state_q)
      StTreeReq: begin
        dma.dma_read_ctrl_valid       = 1'b1;
        dma.dma_read_ctrl_data_index  = tree_index;
        dma.dma_read_ctrl_data_length = 32'(MAX_BURST);
      end
      StTreeData: begin
        dma.dma_read_chnl_ready = 1'b1;
        tree_we                 = dma.dma_read_chnl_valid;
        tree_wdata              = dma.dma_read_chnl_data;
      end
      StFeatReq: begin
        dma.dma_read_ctrl_valid       = 1'b1;
        dma.dma_read_ctrl_data_index  = feat_index;
        dma.dma_read_ctrl_data_length = 32'(FeatBeats);
      end
      StFeatData: begin
        dma.dma_read_chnl_ready = 1'b1;
        feat_we                 = dma.dma_read_chnl_valid;
        feat_wdata              = dma.dma_read_chnl_data;
      end
      default: ;
    endcase
  end

  assign dma.dma_read_ctrl_data_size = 3'b011;
  assign tree_addr    = tree_cnt_q[TreeAw-1:0];
  assign feat_addr    = feat_cnt_q;
  assign sample_valid = sample_valid_q;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);

endmodule

// File: tb/tb_trees_dma_loader.sv
// Bench for trees_dma_loader: a behavioural DMA responder plus a transaction-level model
// of the expected request list, memory writes and sample hand-offs.
module tb_trees_dma_loader;
  localparam int TOTAL = 128 * 256;
  localparam int BURST = 256;
  localparam int FB    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        load_trees;
  logic [15:0] n_samples;
  logic [31:0] base_index;
  logic        tree_we;
  logic [14:0] tree_addr;
  logic [63:0] tree_wdata;
  logic        feat_we;
  logic [3:0]  feat_addr;
  logic [63:0] feat_wdata;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic        done;

  trees_dma_loader_if dma_if ();

  trees_dma_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .load_trees   (load_trees),
    .n_samples    (n_samples),
    .base_index   (base_index),
    .dma          (dma_if),
    .tree_we      (tree_we),
    .tree_addr    (tree_addr),
    .tree_wdata   (tree_wdata),
    .feat_we      (feat_we),
    .feat_addr    (feat_addr),
    .feat_wdata   (feat_wdata),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] idx;
    int          len;
    bit          is_tree;
  } req_t;

  int   checks = 0;
  int   failures = 0;
  req_t exp_q[$];
  int   inflight, tree_writes, feat_writes, req_count, done_count;
  bit   cur_tree, busy_exp, done_next, sample_pending;
  logic [31:0] cur_idx, dma_ptr, m_base;
  int   gap_pct, max_delay, wait_cnt, wait_target, sr_mode;

  function automatic logic [63:0] word(input logic [31:0] i);
    return {i ^ 32'hA5A5_5A5A, i * 32'h9E37_79B1};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected request list straight from the addressing rules.
  task automatic build_expected(input bit lt, input int n, input logic [31:0] base);
    exp_q.delete();
    if (lt) for (int i = 0; i < TOTAL / BURST; i++)
      exp_q.push_back('{base + 32'(i * BURST), BURST, 1'b1});
    for (int s = 0; s < n; s++)
      exp_q.push_back('{base + (lt ? 32'(TOTAL) : 32'd0) + 32'(s * FB), FB, 1'b0});
  endtask

  task automatic model_clear();
    exp_q.delete();
    inflight = 0; busy_exp = 0; done_next = 0; sample_pending = 0;
    wait_cnt = 0; wait_target = 0;
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic step();
    bit ctrl_exp, hs_beat, hs_ctrl;
    dma_if.dma_read_chnl_valid = (inflight > 0) ? ($urandom_range(99) >= gap_pct)
                                                : ($urandom_range(7) == 0);
    dma_if.dma_read_chnl_data  = (inflight > 0 && dma_if.dma_read_chnl_valid) ? word(dma_ptr)
                                                : {$urandom, $urandom};
    dma_if.dma_read_ctrl_ready = (wait_cnt >= wait_target);
    sample_ready = (sr_mode == 2) ? 1'b1 : (sr_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
    #1;
    ctrl_exp = busy_exp && !done_next && exp_q.size() > 0 && inflight == 0 && !sample_pending;
    chk("ctrl_valid", 64'(dma_if.dma_read_ctrl_valid), 64'(ctrl_exp));
    chk("chnl_ready", 64'(dma_if.dma_read_chnl_ready), 64'(inflight > 0));
    chk("sample_valid", 64'(sample_valid), 64'(sample_pending));
    chk("busy", 64'(busy), 64'(busy_exp));
    chk("done", 64'(done), 64'(done_next));
    chk("data_size", 64'(dma_if.dma_read_ctrl_data_size), 64'd3);
    if (dma_if.dma_read_ctrl_valid && exp_q.size() > 0) begin
      chk("req_index", 64'(dma_if.dma_read_ctrl_data_index), 64'(exp_q[0].idx));
      chk("req_length", 64'(dma_if.dma_read_ctrl_data_length), 64'(exp_q[0].len));
    end
    hs_beat = dma_if.dma_read_chnl_valid && dma_if.dma_read_chnl_ready;
    hs_ctrl = dma_if.dma_read_ctrl_valid && dma_if.dma_read_ctrl_ready;
    if (hs_beat && inflight > 0 && cur_tree) begin
      chk("tree_we", 64'(tree_we), 64'd1);
      chk("tree_feat_we", 64'(feat_we), 64'd0);
      chk("tree_addr", 64'(tree_addr), 64'(tree_writes % TOTAL));
      chk("tree_wdata", tree_wdata, word(m_base + 32'(tree_writes)));
    end else if (hs_beat && inflight > 0) begin
      chk("feat_we", 64'(feat_we), 64'd1);
      chk("feat_tree_we", 64'(tree_we), 64'd0);
      chk("feat_addr", 64'(feat_addr), 64'(FB - inflight));
      chk("feat_wdata", feat_wdata, word(cur_idx + 32'(FB - inflight)));
    end else begin
      chk("idle_tree_we", 64'(tree_we), 64'd0);
      chk("idle_feat_we", 64'(feat_we), 64'd0);
    end
    if (done) done_count++;
    if (dma_if.dma_read_ctrl_valid) begin
      if (dma_if.dma_read_ctrl_ready) begin
        wait_cnt = 0;
        wait_target = $urandom_range(max_delay);
      end else wait_cnt++;
    end
    if (hs_ctrl) req_count++;
    if (done_next) begin
      done_next = 0;
      busy_exp = 0;
    end else if (!busy_exp) begin
      if (start) begin
        m_base = base_index;
        build_expected(load_trees, int'(n_samples), base_index);
        tree_writes = 0;
        busy_exp = 1;
        done_next = (exp_q.size() == 0);
      end
    end else if (hs_ctrl && exp_q.size() > 0) begin
      req_t r;
      r = exp_q.pop_front();
      inflight = r.len;
      cur_tree = r.is_tree;
      cur_idx  = r.idx;
      dma_ptr  = dma_if.dma_read_ctrl_data_index;
    end else if (hs_beat && inflight > 0) begin
      if (cur_tree) tree_writes++;
      else feat_writes++;
      dma_ptr++;
      inflight--;
      if (inflight == 0) begin
        if (!cur_tree) sample_pending = 1;
        else if (exp_q.size() == 0) done_next = 1;
      end
    end else if (sample_pending && sample_ready) begin
      sample_pending = 0;
      if (exp_q.size() == 0) done_next = 1;
    end
    @(negedge clk);
  endtask

  task automatic pulse_start(input bit lt, input logic [15:0] n, input logic [31:0] base);
    start = 1'b1; load_trees = lt; n_samples = n; base_index = base;
    step();
    start = 1'b0;
    load_trees = 1'($urandom); n_samples = 16'($urandom); base_index = $urandom;
  endtask

  task automatic run_until_idle(input int bound);
    int c = 0;
    while (busy_exp && c < bound) begin
      step();
      c++;
    end
    chk("finish_in_time", 64'(busy), 64'd0);
  endtask

  task automatic run_until_tree_writes(input int n, input int bound);
    int c = 0;
    while (!(tree_writes >= n && inflight > 0) && c < bound) begin
      step();
      c++;
    end
    chk("reach_tree_data", 64'(tree_writes >= n), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; sample_ready = 1'b0;
    dma_if.dma_read_ctrl_ready = 1'b0;
    dma_if.dma_read_chnl_valid = 1'b0;
    dma_if.dma_read_chnl_data  = '0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ctrl_valid", 64'(dma_if.dma_read_ctrl_valid), 64'd0);
    chk("rst_index", 64'(dma_if.dma_read_ctrl_data_index), 64'd0);
    chk("rst_length", 64'(dma_if.dma_read_ctrl_data_length), 64'd0);
    chk("rst_size", 64'(dma_if.dma_read_ctrl_data_size), 64'd3);
    chk("rst_chnl_ready", 64'(dma_if.dma_read_chnl_ready), 64'd0);
    chk("rst_tree", {tree_wdata[62:0], tree_we} | 64'(tree_addr), 64'd0);
    chk("rst_feat", {feat_wdata[62:0], feat_we} | 64'(feat_addr), 64'd0);
    chk("rst_status", {61'd0, sample_valid, busy, done}, 64'd0);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int snap_req, snap_feat, snap_done;
    logic [31:0] rbase;
    start = 1'b0; load_trees = 1'b0; n_samples = '0; base_index = '0; sample_ready = 1'b0;
    req_count = 0; feat_writes = 0; done_count = 0; tree_writes = 0;
    gap_pct = 0; max_delay = 0; sr_mode = 1;
    model_clear();
    do_reset();

    // Full tree load plus two samples, gap-free; a start while busy must be ignored.
    snap_req = req_count; snap_feat = feat_writes; snap_done = done_count;
    pulse_start(1'b1, 16'd2, 32'h100);
    repeat (300) step();
    pulse_start(1'b0, 16'd5, 32'h999);
    run_until_idle(40000);
    chk("a_requests", 64'(req_count - snap_req), 64'd130);
    chk("a_tree_writes", 64'(tree_writes), 64'(TOTAL));
    chk("a_feat_writes", 64'(feat_writes - snap_feat), 64'd32);
    chk("a_done_pulses", 64'(done_count - snap_done), 64'd1);

    // Random beat gaps and request delays, reset in the middle of tree data.
    gap_pct = 50; max_delay = 5;
    rbase = $urandom;
    pulse_start(1'b1, 16'd1, rbase);
    run_until_tree_writes(2000, 8000);
    do_reset();

    // Restart from the same base: the first request and node data begin at base again.
    snap_req = req_count;
    pulse_start(1'b1, 16'd2, rbase);
    run_until_tree_writes(300, 2000);
    pulse_start(1'b0, 16'd9, 32'h0);
    chk("b_restart_reqs", 64'(req_count - snap_req), 64'd2);
    do_reset();

    // Samples only, with an index that wraps past 2^32.
    snap_feat = feat_writes; snap_done = done_count;
    pulse_start(1'b0, 16'd3, 32'hFFFF_FFF8);
    run_until_idle(2000);
    chk("c_feat_writes", 64'(feat_writes - snap_feat), 64'd48);
    chk("c_done_pulses", 64'(done_count - snap_done), 64'd1);

    // Sample hand-off held back for 20 cycles.
    gap_pct = 0; max_delay = 0; sr_mode = 0;
    pulse_start(1'b0, 16'd1, 32'h40);
    for (int c = 0; c < 200 && !sample_pending; c++) step();
    repeat (20) step();
    chk("d_hold_valid", 64'(sample_valid), 64'd1);
    chk("d_hold_no_req", 64'(dma_if.dma_read_ctrl_valid), 64'd0);
    sr_mode = 2;
    run_until_idle(100);

    // No trees, no samples: straight to done without DMA traffic.
    snap_req = req_count; snap_done = done_count;
    pulse_start(1'b0, 16'd0, 32'h1234);
    run_until_idle(10);
    chk("e_no_requests", 64'(req_count - snap_req), 64'd0);
    chk("e_done_pulses", 64'(done_count - snap_done), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
